// File: rtl/ru_vec_pipe.sv
// Multi-lane softmax reduction pipe: sat(x-ref), optional log2(e) scale, pow2.
// Define RU_VEC_SAT_STATUS_EN to add per-lane sat_flag and sat_sticky outputs.
module ru_vec_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic [LANES*DATA_W-1:0]   in_x,
  input  logic [LANES*DATA_W-1:0]   in_ref,
  input  logic                      sel_mult,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [LANES*DATA_W-1:0]   out_diff,
  output logic [LANES*DATA_W-1:0]   out_pow2
`ifdef RU_VEC_SAT_STATUS_EN
  ,
  output logic [LANES-1:0]          sat_flag,
  output logic [LANES-1:0]          sat_sticky
`endif
);

  localparam int KW   = DATA_W - FRAC_W;
  localparam int KMAX = 2**(KW-1) - 1;
  localparam int SW   = FRAC_W + 1 + KMAX;
  localparam int PW   = 2*DATA_W + 1;
  localparam int CLI  = $rtoi(1.4426950409 * (2.0 ** FRAC_W) + 0.5);

  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W:0]   C_LOG = (DATA_W+1)'(CLI);
  localparam logic signed [DATA_W:0]   C_ONE = (DATA_W+1)'(2**FRAC_W);
  localparam logic signed [PW-1:0]     RND  = PW'(2**(FRAC_W-1));
  localparam logic signed [PW-1:0]     PMAX = PW'(SMAX);
  localparam logic signed [PW-1:0]     PMIN = PW'(SMIN);
  localparam logic [SW-1:0]            RMAX = SW'(SMAX);
  localparam logic [KW:0]              FLIM = (KW+1)'(FRAC_W);

  logic adv;
  logic v1, v2, sel1;
  logic signed [DATA_W-1:0] d_n [LANES];
  logic signed [DATA_W-1:0] d1  [LANES];
  logic signed [DATA_W-1:0] y_n [LANES];
  logic signed [DATA_W-1:0] y2  [LANES];
  logic [DATA_W-1:0]        r_n [LANES];

`ifdef RU_VEC_SAT_STATUS_EN
  logic [LANES-1:0] f1_n, f1, f2_n, f2, f3_n;
`endif

  assign adv      = en & (~valid_out | ready_out);
  assign ready_in = adv;

  always_comb begin
    d_n = '{default: '0};
`ifdef RU_VEC_SAT_STATUS_EN
    f1_n = '0;
`endif
    for (int i = 0; i < LANES; i++) begin : g_s1
      logic [DATA_W:0] t;
      logic            ovf;
      t = {in_x[i*DATA_W+DATA_W-1], in_x[i*DATA_W +: DATA_W]}
        - {in_ref[i*DATA_W+DATA_W-1], in_ref[i*DATA_W +: DATA_W]};
      ovf = t[DATA_W] ^ t[DATA_W-1];
      d_n[i] = ovf ? (t[DATA_W] ? SMIN : SMAX) : t[DATA_W-1:0];
`ifdef RU_VEC_SAT_STATUS_EN
      f1_n[i] = ovf;
`endif
    end
  end

  // Rounded fixed-point multiply; C=2^FRAC_W makes this an exact pass-through
  always_comb begin
    y_n = '{default: '0};
`ifdef RU_VEC_SAT_STATUS_EN
    f2_n = '0;
`endif
    for (int i = 0; i < LANES; i++) begin : g_s2
      logic signed [PW-1:0] p;
      logic signed [PW-1:0] q;
      logic                 hi;
      logic                 lo;
      p  = PW'(d1[i]) * PW'(sel1 ? C_LOG : C_ONE);
      q  = (p + RND) >>> FRAC_W;
      hi = q > PMAX;
      lo = q < PMIN;
      y_n[i] = hi ? SMAX : (lo ? SMIN : q[DATA_W-1:0]);
`ifdef RU_VEC_SAT_STATUS_EN
      f2_n[i] = f1[i] | hi | lo;
`endif
    end
  end

  // Mitchell pow2: integer part shifts the mantissa 1.f
  always_comb begin
    r_n = '{default: '0};
`ifdef RU_VEC_SAT_STATUS_EN
    f3_n = '0;
`endif
    for (int i = 0; i < LANES; i++) begin : g_s3
      logic signed [KW-1:0] k;
      logic [FRAC_W:0]      m;
      logic [SW-1:0]        wide;
      logic [KW:0]          nk;
      logic                 big;
      k    = KW'(y2[i] >>> FRAC_W);
      m    = {1'b1, y2[i][FRAC_W-1:0]};
      wide = SW'(m) << k;
      nk   = -{k[KW-1], k};
      big  = 1'b0;
      if (!k[KW-1]) begin
        big    = wide > RMAX;
        r_n[i] = big ? SMAX : wide[DATA_W-1:0];
      end else begin
        r_n[i] = (nk > FLIM) ? '0 : DATA_W'(m >> nk);
      end
`ifdef RU_VEC_SAT_STATUS_EN
      f3_n[i] = f2[i] | big;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      valid_out <= 1'b0;
      sel1      <= 1'b0;
      d1        <= '{default: '0};
      y2        <= '{default: '0};
      out_diff  <= '0;
      out_pow2  <= '0;
    end else if (adv) begin
      v1        <= valid_in;
      sel1      <= sel_mult;
      d1        <= d_n;
      v2        <= v1;
      y2        <= y_n;
      valid_out <= v2;
      for (int i = 0; i < LANES; i++) begin
        out_diff[i*DATA_W +: DATA_W] <= y2[i];
        out_pow2[i*DATA_W +: DATA_W] <= r_n[i];
      end
    end
  end

`ifdef RU_VEC_SAT_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f1         <= '0;
      f2         <= '0;
      sat_flag   <= '0;
      sat_sticky <= '0;
    end else begin
      if (adv) begin
        f1       <= f1_n;
        f2       <= f2_n;
        sat_flag <= f3_n;
      end
      if (valid_out & ready_out)
        sat_sticky <= sat_sticky | sat_flag;
    end
  end
`endif

endmodule
